// File: rtl/jtcontra_fm_wrseq.sv
// Write sequencer for the jt51 register port: buffers (register, value) pairs and
// replays them as address write, gap, data write and busy polling, paced by cen.
module jtcontra_fm_wrseq #(
    parameter int unsigned AW      = 3,
    parameter int unsigned GAP     = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          flush,
    input  logic          req_valid,
    input  logic [7:0]    req_addr,
    input  logic [7:0]    req_data,
    output logic          req_ready,
    output logic [AW:0]   level,
    output logic          busy,
    output logic          timeout,
    output logic          fm_cs_n,
    output logic          fm_wr_n,
    output logic          fm_a0,
    output logic [7:0]    fm_din,
    input  logic [7:0]    fm_dout
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StGap,
        StData,
        StPoll
    } state_e;

    localparam logic [7:0] GapLast  = 8'(GAP - 1);
    localparam logic [7:0] PollLast = 8'(TIMEOUT - 1);

    state_e        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    mem_a [2**AW];
    logic [7:0]    mem_d [2**AW];
    logic [7:0]    cur_d;
    logic [7:0]    gap_cnt;
    logic [7:0]    poll_cnt;
    logic          push;
    logic          pop;
    logic          unused_dout;

    assign unused_dout = ^fm_dout[6:0];

    // level[AW] is set only when all 2**AW entries are occupied
    assign req_ready = !level[AW];
    assign push      = req_valid && req_ready && !flush;
    assign pop       = cen && (state == StIdle) && (level != '0) && !flush;
    assign busy      = (state != StIdle) || (level != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= req_addr;
            mem_d[wr_ptr] <= req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (flush) begin
                level  <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                if (push && !pop) begin
                    level <= level + (AW+1)'(1);
                end else if (!push && pop) begin
                    level <= level - (AW+1)'(1);
                end
            end
        end
    end

    // Bus outputs are loaded on the transition into each state
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            fm_cs_n  <= 1'b1;
            fm_wr_n  <= 1'b1;
            fm_a0    <= 1'b0;
            fm_din   <= 8'd0;
            timeout  <= 1'b0;
            cur_d    <= 8'd0;
            gap_cnt  <= 8'd0;
            poll_cnt <= 8'd0;
        end else if (cen) begin
            case (state)
                StIdle: begin
                    if (pop) begin
                        cur_d    <= mem_d[rd_ptr];
                        fm_din   <= mem_a[rd_ptr];
                        fm_cs_n  <= 1'b0;
                        fm_wr_n  <= 1'b0;
                        fm_a0    <= 1'b0;
                        poll_cnt <= 8'd0;
                        state    <= StAddr;
                    end
                end
                StAddr: begin
                    fm_cs_n <= 1'b1;
                    fm_wr_n <= 1'b1;
                    gap_cnt <= 8'd0;
                    state   <= StGap;
                end
                StGap: begin
                    if (gap_cnt == GapLast) begin
                        fm_cs_n <= 1'b0;
                        fm_wr_n <= 1'b0;
                        fm_a0   <= 1'b1;
                        fm_din  <= cur_d;
                        state   <= StData;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                StData: begin
                    fm_wr_n <= 1'b1;
                    state   <= StPoll;
                end
                StPoll: begin
                    if (!fm_dout[7]) begin
                        fm_cs_n <= 1'b1;
                        state   <= StIdle;
                    end else if (poll_cnt == PollLast) begin
                        // chip never released busy: drop this entry and move on
                        timeout <= 1'b1;
                        fm_cs_n <= 1'b1;
                        state   <= StIdle;
                    end else begin
                        poll_cnt <= poll_cnt + 8'd1;
                    end
                end
                default: begin
                    fm_cs_n <= 1'b1;
                    fm_wr_n <= 1'b1;
                    state   <= StIdle;
                end
            endcase
        end
    end

endmodule
